// File: rtl/seq_mul_ctrl.sv
// Radix-2 shift-add unsigned multiplier: one add/shift per clock, product valid WIDTH edges after accept.
// Valid/ready on both sides; in_ready only in IDLE, and DONE holds prod until out_ready.

module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

module seq_mul_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   m;
  logic [2*WIDTH-1:0] p;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   sum;
  logic               cout;

  adder #(WIDTH) u_adder (
    .a    (p[2*WIDTH-1:WIDTH]),
    .b    (m),
    .cin  (1'b0),
    .s    (sum),
    .cout (cout)
  );

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign prod      = p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)            state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST)     state_nxt = DONE;
      DONE:    if (out_ready)           state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m   <= '0;
      p   <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          m   <= op_a;
          p   <= {{WIDTH{1'b0}}, op_b};
          cnt <= '0;
        end
        RUN: begin
          // The carry out of the high half becomes the new MSB after the shift.
          if (p[0]) p <= {cout, sum, p[WIDTH-1:1]};
          else      p <= {1'b0, p[2*WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Directed bench for seq_mul_ctrl: hand-computed products, latency, backpressure, reset and back-to-back.
module tb_seq_mul_ctrl;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*W-1:0] prod;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  seq_mul_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one op, measure latency, optionally stall the output, then handshake.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [63:0] exp, input int hold, input bit poke);
    int lat;
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    out_ready = 1'b0;
    check({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = poke;
    check({tag, " in_ready run"}, 64'(in_ready), 64'd0);
    check({tag, " busy run"}, 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd32);
    check({tag, " prod"}, prod, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold valid"}, 64'(out_valid), 64'd1);
      check({tag, " hold prod"}, prod, exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " valid drop"}, 64'(out_valid), 64'd0);
    check({tag, " in_ready back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int cyc, nacc, nres;
    int acc [2];
    logic [63:0] res [2];

    repeat (3) tick();
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst prod", prod, 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post rst in_ready", 64'(in_ready), 64'd1);

    run_op("3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 0, 1'b0);
    run_op("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 1'b0);
    run_op("a0", 32'd0, 32'h1234_5678, 64'd0, 0, 1'b0);
    run_op("b0", 32'h0001_F004, 32'd0, 64'd0, 0, 1'b0);
    run_op("stall", 32'h0000_0004, 32'h0000_F004, 64'h0000_0000_0003_C010, 5, 1'b1);

    // Reset mid-run
    op_a = 32'd7;
    op_b = 32'd9;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    check("midrun busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst out_valid", 64'(out_valid), 64'd0);
    check("arst busy", 64'(busy), 64'd0);
    check("arst prod", prod, 64'd0);
    check("arst in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rerst in_ready", 64'(in_ready), 64'd1);
    check("rerst busy", 64'(busy), 64'd0);
    run_op("2x2", 32'd2, 32'd2, 64'd4, 0, 1'b0);

    // Back-to-back with in_valid held and out_ready high
    op_a = 32'd6;
    op_b = 32'd7;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cyc = 0;
    nacc = 0;
    nres = 0;
    acc[0] = 0; acc[1] = 0;
    res[0] = '0; res[1] = '0;
    for (int i = 0; i < 200 && nres < 2; i++) begin
      if (in_ready && in_valid && nacc < 2) begin
        acc[nacc] = cyc;
        nacc++;
      end
      if (out_valid && nres < 2) begin
        res[nres] = prod;
        nres++;
      end
      tick();
      cyc++;
      if (nacc == 1) begin
        op_a = 32'h8000_0001;
        op_b = 32'h0000_0003;
      end
      if (nacc == 2) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    check("b2b accepts", 64'(nacc), 64'd2);
    check("b2b results", 64'(nres), 64'd2);
    check("b2b gap", 64'(acc[1] - acc[0]), 64'd34);
    check("b2b prod0", res[0], 64'd42);
    check("b2b prod1", res[1], 64'h0000_0001_8000_0003);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
